// File: rtl/mem_arbiter_if.sv
// Bundle of pipeline, aux-port and data-memory signals around the memory arbiter.
// The arbiter uses the slave view; the surrounding system (pipeline, loader, memory) uses master.
interface mem_arbiter_if;
  logic        i_Pipe_MemRead;
  logic        i_Pipe_MemWrite;
  logic [15:0] i_Pipe_Address;
  logic [15:0] i_Pipe_Write_Data;
  logic [15:0] o_Pipe_Read_Data;
  logic        o_Pipe_Stall;

  logic        i_Aux_Req;
  logic        i_Aux_Write;
  logic [15:0] i_Aux_Address;
  logic [15:0] i_Aux_Write_Data;
  logic        o_Aux_Ack;
  logic [15:0] o_Aux_Read_Data;

  logic        o_Sig_MemRead;
  logic        o_Sig_MemWrite;
  logic [15:0] o_Address;
  logic [15:0] o_Write_Data;
  logic [15:0] i_Read_Data;

  modport master (
    output i_Pipe_MemRead, i_Pipe_MemWrite, i_Pipe_Address, i_Pipe_Write_Data,
    input  o_Pipe_Read_Data, o_Pipe_Stall,
    output i_Aux_Req, i_Aux_Write, i_Aux_Address, i_Aux_Write_Data,
    input  o_Aux_Ack, o_Aux_Read_Data,
    input  o_Sig_MemRead, o_Sig_MemWrite, o_Address, o_Write_Data,
    output i_Read_Data
  );

  modport slave (
    input  i_Pipe_MemRead, i_Pipe_MemWrite, i_Pipe_Address, i_Pipe_Write_Data,
    output o_Pipe_Read_Data, o_Pipe_Stall,
    input  i_Aux_Req, i_Aux_Write, i_Aux_Address, i_Aux_Write_Data,
    output o_Aux_Ack, o_Aux_Read_Data,
    output o_Sig_MemRead, o_Sig_MemWrite, o_Address, o_Write_Data,
    input  i_Read_Data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one data memory between the pipeline memory stage and an aux (loader/debug) port.
// The pipeline has priority; a starved aux request steals exactly one stall cycle.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] AUX_ACCESS = 2'd1;
  localparam logic [1:0] AUX_DONE   = 2'd2;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic        aux_ack;
  logic [15:0] aux_rd;
  logic        pipe_req;

  assign pipe_req = bus.i_Pipe_MemRead | bus.i_Pipe_MemWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      aux_ack    <= 1'b0;
      aux_rd     <= 16'h0000;
    end else begin
      aux_ack <= (state == AUX_ACCESS);
      case (state)
        IDLE: begin
          if (!bus.i_Aux_Req) begin
            starve_cnt <= 4'd0;
          end else if (!pipe_req || starve_cnt == LIMIT) begin
            state      <= AUX_ACCESS;
            starve_cnt <= 4'd0;
          end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        AUX_ACCESS: begin
          state <= AUX_DONE;
          if (!bus.i_Aux_Write) aux_rd <= bus.i_Read_Data;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is combinational so the pipeline sees single-cycle access;
  // reset gates the strobes so nothing is written while rst is high.
  always_comb begin
    bus.o_Sig_MemRead  = 1'b0;
    bus.o_Sig_MemWrite = 1'b0;
    bus.o_Address      = bus.i_Pipe_Address;
    bus.o_Write_Data   = bus.i_Pipe_Write_Data;
    bus.o_Pipe_Stall   = 1'b0;
    if (state == AUX_ACCESS) begin
      bus.o_Address    = bus.i_Aux_Address;
      bus.o_Write_Data = bus.i_Aux_Write_Data;
      if (!rst) begin
        bus.o_Sig_MemWrite = bus.i_Aux_Write;
        bus.o_Sig_MemRead  = ~bus.i_Aux_Write;
        bus.o_Pipe_Stall   = pipe_req;
      end
    end else if (!rst) begin
      bus.o_Sig_MemWrite = bus.i_Pipe_MemWrite;
      bus.o_Sig_MemRead  = bus.i_Pipe_MemRead & ~bus.i_Pipe_MemWrite;
    end
  end

  assign bus.o_Pipe_Read_Data = bus.i_Read_Data;
  assign bus.o_Aux_Ack        = aux_ack;
  assign bus.o_Aux_Read_Data  = aux_rd;
endmodule
